// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package dmem_arb_pkg;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned IDX_W  = 5;

  localparam int unsigned P_CORE = 0;
  localparam int unsigned P_LOAD = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with its priority pointer register.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic ptr;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // Pointer moves to the port that was not just granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ptr <= 1'(P_CORE);
    else if (|gnt)   ptr <= gnt[0];
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer sharing one data memory between core and loader ports.
// Optional address range check: define DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = dmem_arb_pkg::DATA_W,
  parameter int unsigned ADDR_W = dmem_arb_pkg::ADDR_W,
  parameter int unsigned DEPTH  = dmem_arb_pkg::DEPTH,
  parameter int unsigned IDX_W  = dmem_arb_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [ADDR_W-1:0] ALUResult,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [DATA_W-1:0] ReadData
);
  state_t            state;
  logic [1:0]        gnt;
  logic              sel;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;
  logic              lat_wr;
  logic              lat_err;
  logic [1:0]        owner;

  rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .en    (state == IDLE),
    .gnt   (gnt)
  );

  always_comb begin
    sel       = gnt[1];
    sel_wr    = sel ? req_write[1] : req_write[0];
    sel_addr  = sel ? req_addr1 : req_addr0;
    sel_wdata = sel ? req_wdata1 : req_wdata0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    sel_err   = (sel_addr >= ADDR_W'(DEPTH));
`else
    sel_err   = 1'b0;
`endif
  end

  assign req_ready = gnt;
  assign rsp_err   = (state == RESP) & lat_err;

  always_comb begin
    rsp_rdata = '0;
    if (state == RESP && !lat_wr && !lat_err) rsp_rdata = ReadData;
  end

  // Strobes and rsp_valid are registered one state ahead so they line up
  // exactly with ISSUE and RESP respectively.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      MemWrite  <= 1'b0;
      MemRead   <= 1'b0;
      rsp_valid <= '0;
      ALUResult <= '0;
      ReadData2 <= '0;
      lat_wr    <= 1'b0;
      lat_err   <= 1'b0;
      owner     <= '0;
    end else begin
      MemWrite  <= 1'b0;
      MemRead   <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|gnt) begin
            lat_wr    <= sel_wr;
            lat_err   <= sel_err;
            owner     <= gnt;
            ALUResult <= ADDR_W'(sel_addr[IDX_W-1:0]);
            ReadData2 <= sel_wdata;
            MemWrite  <= sel_wr & ~sel_err;
            MemRead   <= ~sel_wr & ~sel_err;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_valid <= owner;
          state     <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 32x64 memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_write = '0;
  logic [63:0]       req_addr0 = '0, req_addr1 = '0;
  logic [63:0]       req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0]        req_ready, rsp_valid;
  logic [63:0]       rsp_rdata;
  logic              rsp_err, MemWrite, MemRead;
  logic [63:0]       ALUResult, ReadData2;
  logic [63:0]       ReadData = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .DEPTH(32), .IDX_W(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .MemWrite(MemWrite), .MemRead(MemRead),
    .ALUResult(ALUResult), .ReadData2(ReadData2), .ReadData(ReadData)
  );

  logic [63:0] mem [32];
  always @(posedge clk) begin
    if (MemWrite) mem[ALUResult[4:0]] <= ReadData2;
    if (MemRead)  ReadData <= mem[ALUResult[4:0]];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {logic [1:0] port; logic [63:0] rdata; logic err; int cyc;} rsp_t;
  typedef struct {logic wr; logic [63:0] addr; logic [63:0] wdata;} iss_t;
  rsp_t rsp_q[$];
  iss_t iss_q[$];
  logic [63:0] ref_mem [32];
  int grant_log[$];
  int cyc = 0;
  int strobes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  rsp_t er;
  iss_t ei;
  int   gp;
  logic [63:0] ga;
  logic        gw, gerr;

  always @(negedge clk) begin
    if (reset) begin
      if (req_ready != 2'b00) begin
        check("ready_onehot", 64'($countones(req_ready)), 64'd1);
        gp = req_ready[1] ? 1 : 0;
        gw = req_write[gp];
        ga = gp ? req_addr1 : req_addr0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
        gerr = (ga >= 64'd32);
`else
        gerr = 1'b0;
`endif
        if (!gerr) begin
          iss_q.push_back('{gw, {59'd0, ga[4:0]}, gp ? req_wdata1 : req_wdata0});
          if (gw) ref_mem[ga[4:0]] = gp ? req_wdata1 : req_wdata0;
        end
        rsp_q.push_back('{req_ready, (gw || gerr) ? 64'd0 : ref_mem[ga[4:0]], gerr, cyc});
        grant_log.push_back(gp);
      end
      if (MemRead || MemWrite) begin
        strobes++;
        check("strobe_excl", 64'(MemRead & MemWrite), 64'd0);
        if (iss_q.size() == 0) check("unexpected_strobe", 64'd1, 64'd0);
        else begin
          ei = iss_q.pop_front();
          check("strobe_kind", 64'(MemWrite), 64'(ei.wr));
          check("strobe_addr", ALUResult, ei.addr);
          if (ei.wr) check("strobe_wdata", ReadData2, ei.wdata);
        end
      end
      if (rsp_valid != 2'b00) begin
        if (rsp_q.size() == 0) check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        else begin
          er = rsp_q.pop_front();
          check("rsp_port", 64'(rsp_valid), 64'(er.port));
          check("rsp_rdata", rsp_rdata, er.rdata);
          check("rsp_err", 64'(rsp_err), 64'(er.err));
          check("rsp_latency", 64'(cyc - er.cyc), 64'd2);
        end
      end else begin
        check("rdata_idle", rsp_rdata, 64'd0);
        check("err_idle", 64'(rsp_err), 64'd0);
      end
    end
  end

  task automatic drive(input int p, input logic wr, input logic [63:0] a, input logic [63:0] d);
    req_write[p] = wr;
    if (p == 0) begin req_addr0 = a; req_wdata0 = d; end
    else        begin req_addr1 = a; req_wdata1 = d; end
    req_valid[p] = 1'b1;
  endtask

  task automatic do_req(input int p, input logic wr, input logic [63:0] a, input logic [63:0] d);
    logic got;
    got = 1'b0;
    drive(p, wr, a, d);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready[p];
    end
    if (!got) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && rsp_q.size() != 0; i++) @(negedge clk);
    check("drain_rsp", 64'(rsp_q.size()), 64'd0);
    check("drain_iss", 64'(iss_q.size()), 64'd0);
    rsp_q.delete();
    iss_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  int s0, n0;

  initial begin
    for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    // Reset state
    @(negedge clk);
    check("rst_memwrite", 64'(MemWrite), 64'd0);
    check("rst_memread", 64'(MemRead), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rspvalid", 64'(rsp_valid), 64'd0);
    check("rst_aluresult", ALUResult, 64'd0);
    check("rst_readdata2", ReadData2, 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // Store then load on the core port
    s0 = strobes;
    do_req(0, 1'b1, 64'd5, 64'hDEAD);
    drain();
    check("store_strobes", 64'(strobes - s0), 64'd1);
    do_req(0, 1'b0, 64'd5, 64'd0);
    drain();
    check("load_dead", ref_mem[5], 64'hDEAD);

    // Contention: both ports load continuously for 12 cycles
    pulse_reset();
    s0 = strobes;
    n0 = grant_log.size();
    drive(0, 1'b0, 64'd5, 64'd0);
    drive(1, 1'b0, 64'd7, 64'd0);
    repeat (12) @(posedge clk);
    #1 req_valid = '0;
    drain();
    check("rr_grants", 64'(grant_log.size() - n0), 64'd4);
    for (int i = 0; i < 4 && n0 + i < grant_log.size(); i++)
      check("rr_order", 64'(grant_log[n0 + i]), 64'(i % 2));
    check("rr_strobes", 64'(strobes - s0), 64'd4);

    // Loader port preloads 0..3, core reads back
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b1, 64'(i), 64'h10 + 64'(i));
      drain();
    end
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b0, 64'(i), 64'd0);
      drain();
      check("preload_ref", ref_mem[i], 64'h10 + 64'(i));
    end

    // Reset asserted during ISSUE of a load
    drive(1, 1'b0, 64'd2, 64'd0);
    do_req(1, 1'b0, 64'd2, 64'd0);
    check("issue_read", 64'(MemRead), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_async_read", 64'(MemRead), 64'd0);
    check("rst_async_rsp", 64'(rsp_valid), 64'd0);
    rsp_q.delete();
    iss_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    n0 = grant_log.size();
    drive(0, 1'b0, 64'd1, 64'd0);
    drive(1, 1'b0, 64'd3, 64'd0);
    @(negedge clk);
    @(posedge clk); #1 req_valid = '0;
    drain();
    check("post_rst_grant", (grant_log.size() > n0) ? 64'(grant_log[n0]) : 64'hFF, 64'd0);

    // Port 1 drops valid before ready while port 0 is served
    pulse_reset();
    n0 = grant_log.size();
    drive(0, 1'b0, 64'd1, 64'd0);
    @(negedge clk);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    drive(1, 1'b0, 64'd3, 64'd0);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    drain();
    repeat (2) @(posedge clk); #1;
    check("drop_grants", 64'(grant_log.size() - n0), 64'd1);
    n0 = grant_log.size();
    drive(0, 1'b0, 64'd1, 64'd0);
    drive(1, 1'b0, 64'd3, 64'd0);
    @(negedge clk);
    @(posedge clk); #1 req_valid = '0;
    drain();
    check("drop_ptr_grant", (grant_log.size() > n0) ? 64'(grant_log[n0]) : 64'hFF, 64'd1);

    // Out-of-range address
    s0 = strobes;
    do_req(0, 1'b0, 64'd40, 64'd0);
    drain();
`ifdef DMEM_ARB_RANGE_CHECK_EN
    check("oob_strobes", 64'(strobes - s0), 64'd0);
`else
    check("oob_strobes", 64'(strobes - s0), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
